// File: rtl/clock_domain_arbiter_pkg.sv
// clock_domain_arbiter_pkg: shared CDC handshake types and constants (also used by the importer)
package pClockDomain;

   typedef enum logic {IDLE, WAIT} eCdArbState;

   localparam int ACK_SYNC_DEPTH = 2;

endpackage

// File: rtl/clock_domain_arbiter_rr.sv
// clock_domain_arbiter_rr: combinational rotating priority search returning one-hot grant and index
module mRoundRobin #(
   parameter int pN      = 4,
   parameter int pIdBits = 2
) (
   input  logic [pN-1:0]      req,
   input  logic [pIdBits-1:0] start,
   output logic [pN-1:0]      grant,
   output logic [pIdBits-1:0] idx,
   output logic               any
);

   // scan from the farthest slot back to start so the nearest pending request is the last writer
   always_comb begin
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      for (int k = pN - 1; k >= 0; k--) begin
         if (req[(int'(start) + k) % pN]) begin
            grant                            = '0;
            grant[(int'(start) + k) % pN]    = 1'b1;
            idx                              = pIdBits'((int'(start) + k) % pN);
            any                              = 1'b1;
         end
      end
   end

endmodule

// File: rtl/clock_domain_arbiter.sv
// clock_domain_arbiter: round-robin sharing of one toggle-handshake CDC channel; CLOCK_DOMAIN_ARBITER_FIXED_PRIO_EN selects fixed priority
module clock_domain_arbiter
   import pClockDomain::*;
#(
   parameter  int pBits   = 8,
   parameter  int pN      = 4,
   localparam int pIdBits = (pN > 1) ? $clog2(pN) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [pN-1:0]             in_valid,
   input  logic [pN*pBits-1:0]       in_data,
   output logic [pN-1:0]             in_ready,
   output logic                      cd_req,
   output logic [pIdBits+pBits-1:0]  cd_data,
   input  logic                      cd_ack,
   output logic                      busy
);

   eCdArbState                state, nxt;
   logic [ACK_SYNC_DEPTH-1:0] ack_ff;
   logic                      ack_s;
   logic [pN-1:0]             grant;
   logic [pIdBits-1:0]        win, start;
   logic                      any, accept;
   logic [pBits-1:0]          payload;

   assign ack_s   = ack_ff[0];
   assign busy    = (state == WAIT);
   assign payload = in_data[int'(win)*pBits +: pBits];

`ifdef CLOCK_DOMAIN_ARBITER_FIXED_PRIO_EN
   assign start = '0;
`else
   logic [pIdBits-1:0] rr_ptr;

   assign start = rr_ptr;

   // move the search start just past the last winner so it yields to the others next round
   always_ff @(posedge clk) begin
      if (!rst) rr_ptr <= '0;
      else if (accept) rr_ptr <= (win == pIdBits'(pN - 1)) ? '0 : win + 1'b1;
   end
`endif

   mRoundRobin #(.pN(pN), .pIdBits(pIdBits)) u_rr (
      .req   (in_valid),
      .start (start),
      .grant (grant),
      .idx   (win),
      .any   (any)
   );

   // grant only in IDLE and never while reset is held; leave WAIT once the synchronized ack matches
   always_comb begin
      nxt      = state;
      in_ready = '0;
      accept   = 1'b0;
      if (state == IDLE) begin
         in_ready = rst ? grant : '0;
         accept   = rst & any;
         nxt      = any ? WAIT : IDLE;
      end else begin
         nxt = (ack_s == cd_req) ? IDLE : WAIT;
      end
   end

   // state register and two-flop synchronizer for the asynchronous ack
   always_ff @(posedge clk) begin
      if (!rst) begin
         state  <= IDLE;
         ack_ff <= '0;
      end else begin
         state  <= nxt;
         ack_ff <= {cd_ack, ack_ff[ACK_SYNC_DEPTH-1:1]};
      end
   end

   // launch the accepted word: data registered so it is glitch-free, then toggle the request
   always_ff @(posedge clk) begin
      if (!rst) begin
         cd_req  <= 1'b0;
         cd_data <= '0;
      end else if (accept) begin
         cd_req  <= ~cd_req;
         cd_data <= {win, payload};
      end
   end

endmodule

// File: tb/tb_clock_domain_arbiter.sv
// tb_clock_domain_arbiter: grant table, handshake corner sequences and a random-ack scoreboard run
module tb_clock_domain_arbiter;

   localparam int N = 4;
   localparam int B = 8;

   typedef struct {
      logic [N-1:0] valid;
      logic [N-1:0] rr;
      logic [N-1:0] fp;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         cd_ack = 1'b0;
   logic         cd_req, busy;
   logic [N-1:0] in_valid = '0;
   logic [N-1:0] in_ready;
   logic [N*B-1:0] in_data = '0;
   logic [9:0]   cd_data;

   int           checks = 0;
   int           failures = 0;
   logic [9:0]   exp_q[$];
   int           grants[$];
   int           m_ptr = 0;
   int           n_acc = 0;
   int           w_m;
   logic         prev_req = 1'b0;
   logic [9:0]   prev_data = '0;
   logic [N-1:0] fired = '0;
   bit           auto_ack = 1'b0;
   int           ack_max = 40;
   vec_t         tbl[9];
   logic [N-1:0] exp_r;
   int           seq[N];
   int           k_acc, target;

   always #5 clk = ~clk;

   clock_domain_arbiter #(.pBits(B), .pN(N)) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_data  (in_data),
      .in_ready (in_ready),
      .cd_req   (cd_req),
      .cd_data  (cd_data),
      .cd_ack   (cd_ack),
      .busy     (busy)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   function automatic int model_winner(input logic [N-1:0] v, input int ptr);
      int s;
`ifdef CLOCK_DOMAIN_ARBITER_FIXED_PRIO_EN
      s = 0 * ptr;
`else
      s = ptr;
`endif
      for (int k = 0; k < N; k++) if (v[(s + k) % N]) return (s + k) % N;
      return 0;
   endfunction

   task automatic wait_idle();
      for (int c = 0; c < 200; c++) begin
         @(posedge clk);
         #1;
         if (!busy) return;
      end
      chk("idle_timeout", 32'(busy), 32'(0));
   endtask

   // importer model: echoes the request after a random, clock-unrelated delay
   initial forever begin
      #1;
      if (auto_ack && cd_ack !== cd_req) begin
         #($urandom_range(ack_max, 1));
         if (auto_ack) cd_ack = cd_req;
      end
   end

   // scoreboard: push on handshake, pop and compare when the request toggles
   always @(negedge clk) begin
      fired = '0;
      if (!rst) begin
         exp_q.delete();
         m_ptr     = 0;
         n_acc     = 0;
         prev_req  = 1'b0;
         prev_data = '0;
      end else begin
         if (cd_req !== prev_req) begin
            if (exp_q.size() == 0) chk("spurious_req", 32'(cd_req), 32'(prev_req));
            else chk("cd_data", 32'(cd_data), 32'(exp_q.pop_front()));
            prev_req = cd_req;
         end else if (busy) begin
            chk("cd_data_stable", 32'(cd_data), 32'(prev_data));
            chk("ready_in_wait", 32'(in_ready), 32'(0));
         end
         prev_data = cd_data;
         if (|(in_valid & in_ready)) begin
            w_m = model_winner(in_valid, m_ptr);
            chk("grant_onehot", 32'(in_ready), 32'(1 << w_m));
            exp_q.push_back({2'(w_m), in_data[w_m*B +: B]});
            grants.push_back(w_m);
            m_ptr = (w_m + 1) % N;
            n_acc++;
            fired = in_valid & in_ready;
         end
      end
   end

   initial begin
      tbl[0] = '{4'b0100, 4'b0100, 4'b0100};
      tbl[1] = '{4'b0011, 4'b0001, 4'b0001};
      tbl[2] = '{4'b1001, 4'b1000, 4'b0001};
      tbl[3] = '{4'b1111, 4'b0001, 4'b0001};
      tbl[4] = '{4'b0110, 4'b0010, 4'b0010};
      tbl[5] = '{4'b0001, 4'b0001, 4'b0001};
      tbl[6] = '{4'b1100, 4'b0100, 4'b0100};
      tbl[7] = '{4'b0000, 4'b0000, 4'b0000};
      tbl[8] = '{4'b0110, 4'b0010, 4'b0010};
      for (int i = 0; i < N; i++) in_data[i*B +: B] = 8'(8'h10 + i);

      // reset values, with all requesters valid to confirm no grant leaks during reset
      in_valid = '1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cd_req", 32'(cd_req), 32'(0));
      chk("rst_cd_data", 32'(cd_data), 32'(0));
      chk("rst_busy", 32'(busy), 32'(0));
      chk("rst_in_ready", 32'(in_ready), 32'(0));
      in_valid = '0;
      rst = 1'b1;
      auto_ack = 1'b1;

      // grant table starting from pointer 0
      for (int i = 0; i < 9; i++) begin
         in_valid = tbl[i].valid;
         #1;
`ifdef CLOCK_DOMAIN_ARBITER_FIXED_PRIO_EN
         exp_r = tbl[i].fp;
`else
         exp_r = tbl[i].rr;
`endif
         chk($sformatf("tbl%0d_ready", i), 32'(in_ready), 32'(exp_r));
         @(posedge clk);
         #1;
         in_valid = '0;
         if (exp_r != 0) begin
            chk($sformatf("tbl%0d_busy", i), 32'(busy), 32'(1));
            wait_idle();
         end
      end

      // single word with ack echoed three cycles later
      auto_ack = 1'b0;
      in_data[2*B +: B] = 8'hA5;
      in_valid = 4'b0100;
      #1;
      chk("sw_ready", 32'(in_ready), 32'(4'b0100));
      @(posedge clk);
      #1;
      in_valid = '0;
      chk("sw_req", 32'(cd_req), 32'(n_acc % 2));
      chk("sw_data", 32'(cd_data), 32'({2'd2, 8'hA5}));
      chk("sw_busy", 32'(busy), 32'(1));
      repeat (3) begin
         @(posedge clk);
         #1;
      end
      cd_ack = cd_req;
      @(posedge clk);
      #1;
      chk("sw_busy_m", 32'(busy), 32'(1));
      @(posedge clk);
      #1;
      chk("sw_busy_m1", 32'(busy), 32'(1));
      @(posedge clk);
      #1;
      chk("sw_busy_m2", 32'(busy), 32'(0));
      in_data[2*B +: B] = 8'h12;

      // ack withheld 50 cycles while another requester waits
      in_valid = 4'b0001;
      #1;
      chk("hold_ready", 32'(in_ready), 32'(4'b0001));
      @(posedge clk);
      #1;
      in_valid = 4'b0010;
      for (int c = 0; c < 50; c++) begin
         @(posedge clk);
         #1;
         chk("hold_in_ready", 32'(in_ready), 32'(0));
         chk("hold_cd_data", 32'(cd_data), 32'({2'd0, 8'h10}));
         chk("hold_cd_req", 32'(cd_req), 32'(n_acc % 2));
      end
      cd_ack = cd_req;
      wait_idle();
      chk("hold_next_ready", 32'(in_ready), 32'(4'b0010));
      @(posedge clk);
      #1;
      in_valid = '0;
      auto_ack = 1'b1;
      wait_idle();

      // reset during WAIT drops the word; first grant afterwards goes to requester 0
      auto_ack = 1'b0;
      in_valid = 4'b1000;
      @(posedge clk);
      #1;
      in_valid = '0;
      chk("mr_busy", 32'(busy), 32'(1));
      rst = 1'b0;
      cd_ack = 1'b0;
      in_valid = '1;
      @(posedge clk);
      #1;
      chk("mr_cd_req", 32'(cd_req), 32'(0));
      chk("mr_cd_data", 32'(cd_data), 32'(0));
      chk("mr_busy0", 32'(busy), 32'(0));
      chk("mr_in_ready", 32'(in_ready), 32'(0));
      rst = 1'b1;
      grants.delete();
      #1;
      chk("mr_first", 32'(in_ready), 32'(4'b0001));

      // all four valid continuously with auto-ack
      auto_ack = 1'b1;
      for (int c = 0; c < 500; c++) begin
         @(posedge clk);
         #1;
         if (grants.size() >= 5) break;
      end
      in_valid = '0;
      chk("rr_count", 32'(grants.size() >= 5), 32'(1));
      for (int i = 0; i < 5 && i < grants.size(); i++) begin
`ifdef CLOCK_DOMAIN_ARBITER_FIXED_PRIO_EN
         chk($sformatf("order%0d", i), 32'(grants[i]), 32'(0));
`else
         chk($sformatf("order%0d", i), 32'(grants[i]), 32'(i % N));
`endif
      end
      wait_idle();

      // valid pulsed only during WAIT is never granted
      auto_ack = 1'b0;
      in_valid = 4'b0001;
      @(posedge clk);
      #1;
      in_valid = 4'b0010;
      repeat (3) @(posedge clk);
      #1;
      in_valid = '0;
      k_acc = n_acc;
      cd_ack = cd_req;
      wait_idle();
      repeat (10) @(posedge clk);
      #1;
      chk("pulse_no_grant", 32'(n_acc), 32'(k_acc));
      chk("pulse_req", 32'(cd_req), 32'(k_acc % 2));
      chk("pulse_ready", 32'(in_ready), 32'(0));

      // 1000 words with random requesters and random-phase slow ack
      auto_ack = 1'b1;
      ack_max = 60;
      for (int i = 0; i < N; i++) seq[i] = 0;
      target = n_acc + 1000;
      for (int c = 0; c < 40000; c++) begin
         @(posedge clk);
         #1;
         for (int i = 0; i < N; i++) begin
            if (fired[i]) begin
               seq[i]++;
               in_valid[i] = 1'($urandom_range(1, 0));
               in_data[i*B +: B] = {2'(i), 6'(seq[i])};
            end else if (!in_valid[i] && $urandom_range(3, 0) == 0) begin
               in_valid[i] = 1'b1;
               in_data[i*B +: B] = {2'(i), 6'(seq[i])};
            end
         end
         if (n_acc >= target) break;
      end
      in_valid = '0;
      wait_idle();
      repeat (3) @(posedge clk);
      #1;
      chk("rand_count", 32'(n_acc >= target), 32'(1));
      chk("rand_drained", 32'(exp_q.size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
